rv32i_imem_prefetch: RTL and testbench

Parametrised instruction-fetch front end between the rv32i core's fetch port and the instruction ROM. It replaces the fixed single-cycle ROM hookup with a prefetching, in-order request/response bridge. The bridge tolerates any memory latency of one cycle or more, buffers up to DEPTH sequential instructions and drives the core's stall input. On a non-sequential fetch (branch or jump) it flushes its buffer and discards in-flight responses.

---
 rtl/rv32i_imem_prefetch_pkg.sv | 22 ++
 rtl/rv32i_sync_fifo.sv | 63 ++++++
 rtl/rv32i_imem_prefetch.sv | 173 +++++++++++++++++
 tb/tb_rv32i_imem_prefetch.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_imem_prefetch_pkg.sv
// Shared rv32i fetch-path definitions: instruction width, fetch-state encoding
// and a word-alignment helper.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package rv32i_imem_prefetch_pkg;

  localparam int INSTR_W    = 32;
  // Widest byte address the alignment helper accepts; narrower callers
  // zero-extend in and truncate back out.
  localparam int MAX_ADDR_W = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,  // no sequential stream established yet
    ST_RUN  = 1'b1   // prefetching a sequential stream
  } fetch_state_e;

  // Clear the byte-offset bits so the result addresses a whole 32-bit word.
  function automatic logic [MAX_ADDR_W-1:0] word_align(input logic [MAX_ADDR_W-1:0] addr);
    return {addr[MAX_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32i_sync_fifo.sv
// Synchronous FIFO with synchronous clear, used for instruction prefetch buffering.
// Latency: one cycle from push to visibility at o_head; o_head is a combinational read.
// Backpressure: pushes while full (without a pop) and pops while empty are ignored;
//   the producer is expected to respect o_full / o_count.
// Ports: i_clk/i_reset (async, active-high), i_push/i_push_data, i_pop, i_clear,
//   o_head (oldest entry), o_count, o_empty, o_full.
module rv32i_sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign w_do_pop  = i_pop  && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Storage needs no reset: entries are only observed once count says they are valid.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/rv32i_imem_prefetch.sv
// Prefetching in-order bridge between the rv32i fetch port and the instruction ROM.
// Latency: redirect at t -> first mem_re at t+1 -> instr_valid at t+1+L (bypass);
//   one instruction per cycle in a sequential stream once DEPTH covers the memory latency L.
// Backpressure: stall = fetch_re & ~instr_valid; requests are credit-limited so that
//   buffered + outstanding words never exceed DEPTH.
// Ports: clk, reset (async, active-high); core side fetch_re/fetch_addr -> instr/
//   instr_valid/stall; memory side mem_re/mem_addr -> mem_oe/mem_data (in order);
//   perf_hits/perf_stalls/perf_flushes, built only with RV32I_IMEM_PREFETCH_PERF_EN
//   defined and tied to 0 otherwise.
module rv32i_imem_prefetch
  import rv32i_imem_prefetch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_re,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               stall,
  output logic               mem_re,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_oe,
  input  logic [INSTR_W-1:0] mem_data,
  output logic [31:0]        perf_hits,
  output logic [31:0]        perf_stalls,
  output logic [31:0]        perf_flushes
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;

  logic [ADDR_W-1:0] r_exp_addr;     // address of the FIFO head
  logic [ADDR_W-1:0] r_req_addr;     // next address to request
  logic [CNT_W-1:0]  r_outstanding;  // issued, not yet answered
  logic [CNT_W-1:0]  r_drop;         // how many of the outstanding are stale

  logic [INSTR_W-1:0] w_fifo_head;
  logic [CNT_W-1:0]   w_fifo_count;
  logic               w_fifo_empty;
  logic               w_fifo_full;

  logic [ADDR_W-1:0] w_fetch_aligned;
  logic              w_addr_match;
  logic              w_mem_valid;
  logic              w_resp_live;
  logic              w_bypass;
  logic [CNT_W:0]    w_credit_sum;
  logic              w_credit_ok;
  logic              w_redirect;
  logic              w_hit;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;

  assign w_fetch_aligned = ADDR_W'(word_align(MAX_ADDR_W'(fetch_addr)));
  assign w_addr_match    = (w_fetch_aligned == r_exp_addr);

  // A response with nothing outstanding is a leftover from before reset: ignore it.
  assign w_mem_valid = mem_oe && (r_outstanding != '0);
  assign w_resp_live = w_mem_valid && (r_drop == '0);
  assign w_bypass    = w_fifo_empty && w_resp_live;

  // Credit uses only registered state, keeping mem_oe/mem_data off the mem_re path.
  assign w_credit_sum = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
  assign w_credit_ok  = !w_fifo_full && (w_credit_sum < (CNT_W + 1)'(DEPTH));

  always_comb begin
    w_state_nxt = r_state;
    w_redirect  = 1'b0;
    w_hit       = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (fetch_re) begin
          w_redirect  = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (fetch_re && !w_addr_match) begin
          w_redirect = 1'b1;
        end else begin
          w_hit   = fetch_re && (!w_fifo_empty || w_bypass);
          w_issue = w_credit_ok;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bypassed words go straight to the core and are never written.
  assign w_pop  = w_hit && !w_fifo_empty;
  assign w_push = w_resp_live && !w_redirect && !(w_hit && w_fifo_empty);

  assign instr_valid = w_hit;
  assign instr       = w_hit ? (w_fifo_empty ? mem_data : w_fifo_head) : '0;
  assign stall       = !reset && fetch_re && !w_hit;
  assign mem_re      = w_issue;
  assign mem_addr    = w_issue ? r_req_addr : '0;

  rv32i_sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_push      (w_push),
    .i_push_data (mem_data),
    .i_pop       (w_pop),
    .i_clear     (w_redirect),
    .o_head      (w_fifo_head),
    .o_count     (w_fifo_count),
    .o_empty     (w_fifo_empty),
    .o_full      (w_fifo_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_exp_addr    <= '0;
      r_req_addr    <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= r_outstanding + CNT_W'(w_issue) - CNT_W'(w_mem_valid);
      if (w_redirect) begin
        r_exp_addr <= w_fetch_aligned;
        r_req_addr <= w_fetch_aligned;
        // Everything still in flight belongs to the old stream; a response
        // arriving this very cycle is already discarded by the clear.
        r_drop     <= r_outstanding - CNT_W'(w_mem_valid);
      end else begin
        if (w_hit)   r_exp_addr <= r_exp_addr + WORD_STEP;
        if (w_issue) r_req_addr <= r_req_addr + WORD_STEP;
        if (w_mem_valid && (r_drop != '0)) r_drop <= r_drop - CNT_W'(1);
      end
    end
  end

`ifdef RV32I_IMEM_PREFETCH_PERF_EN
  logic [31:0] r_perf_hits;
  logic [31:0] r_perf_stalls;
  logic [31:0] r_perf_flushes;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_hits    <= '0;
      r_perf_stalls  <= '0;
      r_perf_flushes <= '0;
    end else begin
      if (w_hit)      r_perf_hits    <= r_perf_hits + 32'd1;
      if (stall)      r_perf_stalls  <= r_perf_stalls + 32'd1;
      if (w_redirect) r_perf_flushes <= r_perf_flushes + 32'd1;
    end
  end

  assign perf_hits    = r_perf_hits;
  assign perf_stalls  = r_perf_stalls;
  assign perf_flushes = r_perf_flushes;
`else
  assign perf_hits    = '0;
  assign perf_stalls  = '0;
  assign perf_flushes = '0;
`endif

endmodule

// File: tb/tb_rv32i_imem_prefetch.sv
// Bench for rv32i_imem_prefetch: an in-order memory with settable latency and a
// core model that fetches sequential streams and compares against expected words.
module tb_rv32i_imem_prefetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_re;
  logic [31:0] fetch_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic        mem_oe = 1'b0;
  logic [31:0] mem_data = 32'h0;
  logic [31:0] perf_hits, perf_stalls, perf_flushes;

  rv32i_imem_prefetch #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_re     (fetch_re),
    .fetch_addr   (fetch_addr),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .stall        (stall),
    .mem_re       (mem_re),
    .mem_addr     (mem_addr),
    .mem_oe       (mem_oe),
    .mem_data     (mem_data),
    .perf_hits    (perf_hits),
    .perf_stalls  (perf_stalls),
    .perf_flushes (perf_flushes)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 1;
  int n_mem_re = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t       mq[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_req_addr = 32'h0;
  bit          chk_req = 1'b0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: capture requests away from the edge, answer in order L cycles later.
  always @(negedge clk) begin
    if (!reset && mem_re) begin
      mq.push_back('{addr: mem_addr, due: cyc + lat});
      n_mem_re++;
      if (chk_req) begin
        check("mem_addr", mem_addr, exp_req_addr);
        exp_req_addr += 32'd4;
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      mem_oe   = 1'b1;
      mem_data = memf(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      mem_oe   = 1'b0;
      mem_data = $urandom();
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // Core model: redirect to start, then consume n sequential words.
  task automatic run_fetch(input logic [31:0] start, input int n,
                           output int first_lat, output int gaps);
    int          got;
    int          cycles;
    logic [31:0] a;
    logic [31:0] e;
    got = 0; cycles = 0; a = start; first_lat = -1; gaps = 0;
    next_cycle();
    fetch_re = 1'b1;
    fetch_addr = a;
    exp_q.push_back(memf(a));
    exp_req_addr = start;
    chk_req = 1'b1;
    while (got < n && cycles < 64) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) check("mem_re_on_redirect", {31'd0, mem_re}, 32'd0);
      if (instr_valid) begin
        e = exp_q.pop_front();
        check("instr", instr, e);
        check("stall_on_hit", {31'd0, stall}, 32'd0);
        if (first_lat < 0) first_lat = cycles - 1;
        got++;
        a += 32'd4;
        next_cycle();
        if (got < n) begin
          fetch_addr = a;
          exp_q.push_back(memf(a));
        end else begin
          fetch_re = 1'b0;
        end
      end else begin
        check("stall_on_miss", {31'd0, stall}, 32'd1);
        check("instr_zero_on_miss", instr, 32'd0);
        if (first_lat >= 0) gaps++;
      end
    end
    if (got < n) begin
      check("stream_complete", 32'(got), 32'(n));
      exp_q.delete();
      fetch_re = 1'b0;
    end
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_instr"},        instr,                  32'd0);
    check({tag, "_instr_valid"},  {31'd0, instr_valid},   32'd0);
    check({tag, "_stall"},        {31'd0, stall},         32'd0);
    check({tag, "_mem_re"},       {31'd0, mem_re},        32'd0);
    check({tag, "_mem_addr"},     mem_addr,               32'd0);
    check({tag, "_perf_hits"},    perf_hits,              32'd0);
    check({tag, "_perf_stalls"},  perf_stalls,            32'd0);
    check({tag, "_perf_flushes"}, perf_flushes,           32'd0);
  endtask

  typedef struct {
    logic [31:0] start;
    int          lat;
    int          n;
    int          exp_first;
  } vec_t;

  initial begin
    vec_t        vecs[4];
    int          fl;
    int          g;
    logic [31:0] flush_before;

    // Latencies are non-decreasing so the in-order memory never reorders.
    vecs[0] = '{32'h0000_0000, 1, 8, 2};
    vecs[1] = '{32'h0000_1000, 2, 6, 3};
    vecs[2] = '{32'hFFFF_FFF8, 2, 4, 3};
    vecs[3] = '{32'h0000_0100, 3, 6, 4};

    // Reset with a fetch request present: every output must read 0.
    reset = 1'b1;
    fetch_re = 1'b1;
    fetch_addr = 32'h0000_1234;
    repeat (3) @(negedge clk);
    check_quiet_outputs("in_reset");

    next_cycle();
    reset = 1'b0;
    fetch_re = 1'b0;
    fetch_addr = 32'h0;
    repeat (6) begin
      @(negedge clk);
      check("idle_mem_re", {31'd0, mem_re}, 32'd0);
      check("idle_instr_valid", {31'd0, instr_valid}, 32'd0);
      check("idle_stall", {31'd0, stall}, 32'd0);
    end

    // Sequential streams, including the wrap at the top of the address space.
    for (int i = 0; i < 4; i++) begin
      lat = vecs[i].lat;
      run_fetch(vecs[i].start, vecs[i].n, fl, g);
      check("first_latency", 32'(fl), 32'(vecs[i].exp_first));
      check("stream_gaps", 32'(g), 32'd0);
    end

    // Let the prefetcher fill and the memory drain before changing latency.
    repeat (12) next_cycle();
    lat = 3;

    // fetch_re held low after start: exactly DEPTH requests, then one per pop.
    next_cycle();
    fetch_re = 1'b1;
    fetch_addr = 32'h0000_0500;
    exp_req_addr = 32'h0000_0500;
    n_mem_re = 0;
    next_cycle();
    fetch_re = 1'b0;
    repeat (18) next_cycle();
    check("hold_request_count", 32'(n_mem_re), 32'd4);
    n_mem_re = 0;
    fetch_re = 1'b1;
    exp_q.push_back(memf(32'h0000_0500));
    @(negedge clk);
    check("hold_hit_valid", {31'd0, instr_valid}, 32'd1);
    check("hold_hit_instr", instr, exp_q.pop_front());
    next_cycle();
    fetch_re = 1'b0;
    repeat (10) next_cycle();
    check("refill_request_count", 32'(n_mem_re), 32'd1);

    // Redirect while three requests are in flight: their data must be dropped.
    flush_before = perf_flushes;
    next_cycle();
    fetch_re = 1'b1;
    fetch_addr = 32'h0000_0800;
    exp_req_addr = 32'h0000_0800;
    next_cycle();
    fetch_re = 1'b0;
    @(posedge clk);
    @(posedge clk);
    run_fetch(32'h0000_0100, 3, fl, g);
    check("drop_first_latency", 32'(fl), 32'd4);
    check("drop_stream_gaps", 32'(g), 32'd0);
`ifdef RV32I_IMEM_PREFETCH_PERF_EN
    check("perf_flushes_delta", perf_flushes - flush_before, 32'd2);
`else
    check("perf_flushes_tied", perf_flushes, 32'd0);
    check("perf_flushes_before", flush_before, 32'd0);
`endif

    // Reset with two requests outstanding: their late responses must be ignored.
    repeat (10) next_cycle();
    next_cycle();
    fetch_re = 1'b1;
    fetch_addr = 32'h0000_0900;
    exp_req_addr = 32'h0000_0900;
    next_cycle();
    fetch_re = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check_quiet_outputs("mid_reset");
    next_cycle();
    reset = 1'b0;
    run_fetch(32'h0000_0040, 2, fl, g);
    check("post_reset_first_latency", 32'(fl), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000ns, expected test end");
    $fatal(1);
  end

endmodule
